// File: rtl/keyed_lut_reg.sv
// keyed_lut_reg: runtime-programmable key/value lookup table with a
// registered lookup response, hit/index/multi-hit flags and saturating
// hit/miss statistics.
//
// Handshake: a request is accepted on a cycle where req_valid && req_ready.
// req_ready = !resp_valid || resp_ready depends only on the response register
// and resp_ready, never on req_valid. The result appears in the response
// register one edge after the accept. resp_valid stays high, and every resp_*
// output holds, until a cycle with resp_ready=1. If no new accept happens in
// that cycle, resp_valid then falls.
module keyed_lut_reg #(
    parameter int NR_KEY      = 4,
    parameter int KEY_LEN     = 2,
    parameter int DATA_LEN    = 2,
    parameter int HAS_DEFAULT = 1,
    parameter int CNT_W       = 8,
    localparam int IDX_W      = $clog2(NR_KEY)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [KEY_LEN-1:0]  wr_key,
    input  logic [DATA_LEN-1:0] wr_data,
    input  logic [DATA_LEN-1:0] default_out,
    input  logic                req_valid,
    input  logic [KEY_LEN-1:0]  req_key,
    output logic                req_ready,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_LEN-1:0] resp_data,
    output logic                resp_hit,
    output logic [IDX_W-1:0]    resp_idx,
    output logic                resp_multi,
    output logic [CNT_W-1:0]    stat_hits,
    output logic [CNT_W-1:0]    stat_misses
);

    logic                tbl_vld  [NR_KEY];
    logic [KEY_LEN-1:0]  tbl_key  [NR_KEY];
    logic [DATA_LEN-1:0] tbl_data [NR_KEY];

    logic                lk_hit;
    logic                lk_multi;
    logic [IDX_W-1:0]    lk_idx;
    logic [DATA_LEN-1:0] lk_data;
    logic                accept;

    assign req_ready = !resp_valid || resp_ready;
    assign accept    = req_valid && req_ready;

    // Table storage. clr beats a same-cycle write. An index with no matching
    // entry (only possible when NR_KEY is not a power of 2) writes nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NR_KEY; i++) begin
                tbl_vld[i]  <= 1'b0;
                tbl_key[i]  <= '0;
                tbl_data[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < NR_KEY; i++) begin
                tbl_vld[i] <= 1'b0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NR_KEY; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    tbl_vld[i]  <= 1'b1;
                    tbl_key[i]  <= wr_key;
                    tbl_data[i] <= wr_data;
                end
            end
        end
    end

    // Parallel compare. The lowest matching index wins. Any later match only
    // raises the multi-hit flag, so data from two entries is never combined.
    always_comb begin
        lk_hit   = 1'b0;
        lk_multi = 1'b0;
        lk_idx   = '0;
        lk_data  = (HAS_DEFAULT != 0) ? default_out : '0;
        for (int i = 0; i < NR_KEY; i++) begin
            if (tbl_vld[i] && (tbl_key[i] == req_key)) begin
                if (lk_hit) begin
                    lk_multi = 1'b1;
                end else begin
                    lk_hit  = 1'b1;
                    lk_idx  = IDX_W'(i);
                    lk_data = tbl_data[i];
                end
            end
        end
    end

    // Response register. It loads on accept and drains when taken without a
    // refill. Because the lookup uses the pre-edge table, a same-cycle write
    // or clr is not visible to it.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_hit   <= 1'b0;
            resp_idx   <= '0;
            resp_multi <= 1'b0;
        end else if (accept) begin
            resp_valid <= 1'b1;
            resp_data  <= lk_data;
            resp_hit   <= lk_hit;
            resp_idx   <= lk_idx;
            resp_multi <= lk_multi;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

    // Saturating statistics. Only accepted lookups count, and only rst
    // clears the counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (accept) begin
            if (lk_hit) begin
                if (stat_hits != {CNT_W{1'b1}}) stat_hits <= stat_hits + 1'b1;
            end else begin
                if (stat_misses != {CNT_W{1'b1}}) stat_misses <= stat_misses + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_keyed_lut_reg.sv
// Directed bench for keyed_lut_reg. The main instance uses default
// parameters. A second instance with CNT_W=2 shares the same inputs and
// covers counter saturation.
module tb_keyed_lut_reg;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       wr_en;
    logic [1:0] wr_idx;
    logic [1:0] wr_key;
    logic [1:0] wr_data;
    logic [1:0] default_out;
    logic       req_valid;
    logic [1:0] req_key;
    logic       resp_ready;

    logic       req_ready, resp_valid, resp_hit, resp_multi;
    logic [1:0] resp_data, resp_idx;
    logic [7:0] stat_hits, stat_misses;

    logic       b_req_ready, b_resp_valid, b_resp_hit, b_resp_multi;
    logic [1:0] b_resp_data, b_resp_idx;
    logic [1:0] b_stat_hits, b_stat_misses;

    int vectors = 0;
    int errs    = 0;
    logic [1:0] exp_q[$];

    keyed_lut_reg dut (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_key(wr_key), .wr_data(wr_data), .default_out(default_out),
        .req_valid(req_valid), .req_key(req_key), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_hit(resp_hit), .resp_idx(resp_idx), .resp_multi(resp_multi),
        .stat_hits(stat_hits), .stat_misses(stat_misses)
    );

    keyed_lut_reg #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_key(wr_key), .wr_data(wr_data), .default_out(default_out),
        .req_valid(req_valid), .req_key(req_key), .req_ready(b_req_ready),
        .resp_valid(b_resp_valid), .resp_ready(resp_ready), .resp_data(b_resp_data),
        .resp_hit(b_resp_hit), .resp_idx(b_resp_idx), .resp_multi(b_resp_multi),
        .stat_hits(b_stat_hits), .stat_misses(b_stat_misses)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge. Registered outputs are settled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [1:0] idx, input logic [1:0] key, input logic [1:0] data);
        wr_en = 1'b1; wr_idx = idx; wr_key = key; wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        vectors++; if (resp_valid !== 1'b0) begin $display("FAIL reset_resp_valid: got %b want 0", resp_valid); errs++; end
        vectors++; if (stat_hits !== 8'd0 || stat_misses !== 8'd0) begin $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_hits, stat_misses); errs++; end
        vectors++; if ({resp_data, resp_hit, resp_idx, resp_multi} !== 6'd0) begin $display("FAIL reset_resp: got %b want 000000", {resp_data, resp_hit, resp_idx, resp_multi}); errs++; end
        vectors++; if (req_ready !== 1'b1) begin $display("FAIL reset_req_ready: got %b want 1", req_ready); errs++; end
    endtask

    task automatic test_miss_default();
        default_out = 2'b11; resp_ready = 1'b1;
        req_valid = 1'b1; req_key = 2'b01;
        tick();
        req_valid = 1'b0;
        vectors++; if (resp_valid !== 1'b1) begin $display("FAIL miss_valid: got %b want 1", resp_valid); errs++; end
        vectors++; if (resp_hit !== 1'b0 || resp_idx !== 2'd0 || resp_multi !== 1'b0) begin $display("FAIL miss_flags: got hit=%b idx=%0d multi=%b want 0/0/0", resp_hit, resp_idx, resp_multi); errs++; end
        vectors++; if (resp_data !== 2'b11) begin $display("FAIL miss_data: got %b want 11", resp_data); errs++; end
        vectors++; if (stat_misses !== 8'd1 || stat_hits !== 8'd0) begin $display("FAIL miss_stats: got h=%0d m=%0d want 0/1", stat_hits, stat_misses); errs++; end
        tick();
        vectors++; if (resp_valid !== 1'b0) begin $display("FAIL miss_drain: got %b want 0", resp_valid); errs++; end
    endtask

    task automatic test_multi_hit();
        do_write(2'd0, 2'b10, 2'b01);
        do_write(2'd2, 2'b10, 2'b11);
        req_valid = 1'b1; req_key = 2'b10;
        tick();
        req_valid = 1'b0;
        vectors++; if (resp_hit !== 1'b1 || resp_idx !== 2'd0 || resp_multi !== 1'b1) begin $display("FAIL multi_flags: got hit=%b idx=%0d multi=%b want 1/0/1", resp_hit, resp_idx, resp_multi); errs++; end
        vectors++; if (resp_data !== 2'b01) begin $display("FAIL multi_data: got %b want 01", resp_data); errs++; end
        vectors++; if (stat_hits !== 8'd1) begin $display("FAIL multi_stat_hits: got %0d want 1", stat_hits); errs++; end
        tick();
    endtask

    task automatic test_backpressure();
        resp_ready = 1'b0;
        req_valid = 1'b1; req_key = 2'b10;
        tick();
        req_key = 2'b01;
        #1;
        vectors++; if (req_ready !== 1'b0) begin $display("FAIL bp_req_ready: got %b want 0", req_ready); errs++; end
        tick();
        tick();
        vectors++; if (resp_valid !== 1'b1 || resp_hit !== 1'b1 || resp_data !== 2'b01 || resp_idx !== 2'd0 || resp_multi !== 1'b1) begin
            $display("FAIL bp_hold: got v=%b h=%b d=%b i=%0d m=%b want 1/1/01/0/1", resp_valid, resp_hit, resp_data, resp_idx, resp_multi); errs++; end
        vectors++; if (stat_hits !== 8'd2 || stat_misses !== 8'd1) begin $display("FAIL bp_stats: got h=%0d m=%0d want 2/1", stat_hits, stat_misses); errs++; end
        resp_ready = 1'b1;
        #1;
        vectors++; if (req_ready !== 1'b1) begin $display("FAIL bp_release_ready: got %b want 1", req_ready); errs++; end
        tick();
        req_valid = 1'b0;
        vectors++; if (resp_valid !== 1'b1 || resp_hit !== 1'b0 || resp_data !== 2'b11) begin $display("FAIL bp_release_resp: got v=%b h=%b d=%b want 1/0/11", resp_valid, resp_hit, resp_data); errs++; end
        vectors++; if (stat_misses !== 8'd2) begin $display("FAIL bp_release_misses: got %0d want 2", stat_misses); errs++; end
        tick();
    endtask

    task automatic test_same_cycle_write();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        wr_en = 1'b1; wr_idx = 2'd1; wr_key = 2'b11; wr_data = 2'b10;
        req_valid = 1'b1; req_key = 2'b11;
        tick();
        wr_en = 1'b0;
        vectors++; if (resp_hit !== 1'b0 || resp_data !== 2'b11) begin $display("FAIL rw_old_table: got h=%b d=%b want 0/11", resp_hit, resp_data); errs++; end
        tick();
        req_valid = 1'b0;
        vectors++; if (resp_hit !== 1'b1 || resp_data !== 2'b10 || resp_idx !== 2'd1 || resp_multi !== 1'b0) begin
            $display("FAIL rw_new_table: got h=%b d=%b i=%0d m=%b want 1/10/1/0", resp_hit, resp_data, resp_idx, resp_multi); errs++; end
        vectors++; if (stat_hits !== 8'd3 || stat_misses !== 8'd3) begin $display("FAIL rw_stats: got h=%0d m=%0d want 3/3", stat_hits, stat_misses); errs++; end
        tick();
    endtask

    task automatic test_clr_vs_write();
        clr = 1'b1;
        wr_en = 1'b1; wr_idx = 2'd3; wr_key = 2'b01; wr_data = 2'b01;
        tick();
        clr = 1'b0; wr_en = 1'b0;
        req_valid = 1'b1; req_key = 2'b01;
        tick();
        vectors++; if (resp_hit !== 1'b0 || resp_data !== 2'b11) begin $display("FAIL clr_wins: got h=%b d=%b want 0/11", resp_hit, resp_data); errs++; end
        req_key = 2'b11;
        tick();
        req_valid = 1'b0;
        vectors++; if (resp_hit !== 1'b0) begin $display("FAIL clr_invalidates: got h=%b want 0", resp_hit); errs++; end
        vectors++; if (stat_hits !== 8'd3 || stat_misses !== 8'd5) begin $display("FAIL clr_stats: got h=%0d m=%0d want 3/5", stat_hits, stat_misses); errs++; end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [1:0] keys [4];
        logic [1:0] exp;
        keys[0] = 2'b00; keys[1] = 2'b01; keys[2] = 2'b10; keys[3] = 2'b00;
        do_write(2'd0, 2'b00, 2'b10);
        do_write(2'd1, 2'b01, 2'b01);
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b11);
        exp_q.push_back(2'b10);
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_key = keys[i];
            tick();
            exp = exp_q.pop_front();
            vectors++; if (resp_valid !== 1'b1 || resp_data !== exp) begin $display("FAIL b2b_%0d: got v=%b d=%b want 1/%b", i, resp_valid, resp_data, exp); errs++; end
        end
        req_valid = 1'b0;
        vectors++; if (stat_hits !== 8'd6 || stat_misses !== 8'd6) begin $display("FAIL b2b_stats: got h=%0d m=%0d want 6/6", stat_hits, stat_misses); errs++; end
        tick();
    endtask

    task automatic test_saturation();
        logic [1:0] exp_h;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        do_write(2'd0, 2'b10, 2'b01);
        req_valid = 1'b1; req_key = 2'b10; resp_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            exp_h = (i >= 3) ? 2'd3 : 2'(i);
            vectors++; if (b_stat_hits !== exp_h) begin $display("FAIL sat_hits_%0d: got %0d want %0d", i, b_stat_hits, exp_h); errs++; end
        end
        vectors++; if (stat_hits !== 8'd5) begin $display("FAIL sat_wide_hits: got %0d want 5", stat_hits); errs++; end
        rst = 1'b1;
        tick();
        rst = 1'b0; req_valid = 1'b0;
        vectors++; if (b_resp_valid !== 1'b0 || b_stat_hits !== 2'd0 || b_stat_misses !== 2'd0) begin
            $display("FAIL sat_reset: got v=%b h=%0d m=%0d want 0/0/0", b_resp_valid, b_stat_hits, b_stat_misses); errs++; end
        vectors++; if (resp_valid !== 1'b0 || stat_hits !== 8'd0 || stat_misses !== 8'd0) begin
            $display("FAIL sat_reset_wide: got v=%b h=%0d m=%0d want 0/0/0", resp_valid, stat_hits, stat_misses); errs++; end
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_key = '0; wr_data = '0;
        default_out = 2'b11; req_valid = 1'b0; req_key = '0; resp_ready = 1'b1;
        test_reset();
        test_miss_default();
        test_multi_hit();
        test_backpressure();
        test_same_cycle_write();
        test_clr_vs_write();
        test_back_to_back();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/keyed_lut_reg.md
Name: keyed_lut_reg

Overview:
Runtime-programmable key/value lookup table. It replaces fixed-constant key-select muxes wherever the key-to-data mapping must change during operation, such as decode tables and remap tables. Entries are written through a write port. Lookups use a valid/ready request, return a registered response with hit, index and multi-hit flags, and update saturating hit/miss statistics.

Parameters:
NR_KEY, 4, number of table entries (>=2); IDX_W = $clog2(NR_KEY) is a derived localparam
KEY_LEN, 2, key width in bits
DATA_LEN, 2, data width in bits
HAS_DEFAULT, 1, 1: a miss returns default_out; 0: a miss returns all-zero data
CNT_W, 8, width of the saturating hit/miss statistic counters

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous reset, active-high
clr  in  1  invalidate all entries (single-cycle pulse)
wr_en  in  1  write one entry this cycle
wr_idx  in  IDX_W  entry index to write
wr_key  in  KEY_LEN  key stored into the entry
wr_data  in  DATA_LEN  data stored into the entry
default_out  in  DATA_LEN  miss value, sampled when a request is accepted
req_valid  in  1  lookup request present
req_key  in  KEY_LEN  key to look up
req_ready  out  1  block can accept a request this cycle
resp_valid  out  1  response register holds a result
resp_ready  in  1  consumer takes the response
resp_data  out  DATA_LEN  looked-up data
resp_hit  out  1  at least one valid entry matched
resp_idx  out  IDX_W  index of the winning entry (0 on miss)
resp_multi  out  1  two or more valid entries matched
stat_hits  out  CNT_W  saturating count of accepted lookups that hit
stat_misses  out  CNT_W  saturating count of accepted lookups that missed

Behaviour:
- Reset (rst=1 at posedge) clears the table and every output:
  - all entry valid bits, keys and data are 0;
  - resp_valid, resp_data, resp_hit, resp_idx, resp_multi, stat_hits and stat_misses are 0.
  - A reset mid-transaction drops any pending response with no handshake.
- Table storage: per entry {vld, key[KEY_LEN], data[DATA_LEN]}.
- Write: on wr_en=1 with wr_idx<NR_KEY, the entry becomes {1, wr_key, wr_data} at the next edge.
  - wr_idx>=NR_KEY (possible when NR_KEY is not a power of 2) is ignored silently.
  - Writing a key that duplicates another entry's key is legal.
- Clear: clr=1 zeroes every vld bit at the next edge; key/data contents need not change.
  - clr and wr_en in the same cycle: clr wins and the write is dropped.
- Handshake:
  - req_ready = !resp_valid || resp_ready, combinational; there is no combinational path from req_valid.
  - Accept occurs when req_valid && req_ready.
  - Latency: exactly 1 cycle. After the accept edge, resp_valid=1 with the result.
  - resp_valid falls only when resp_ready=1 and no new accept happens in that same cycle.
  - Back-to-back accepts give 1 result per cycle while resp_ready is held at 1.
  - While resp_valid=1 and resp_ready=0, all resp_* outputs hold stable.
- Match rule: entry i matches when vld[i] && key[i]==req_key.
  - resp_hit = OR of all matches.
  - The winner is the lowest matching index: resp_idx = that index, resp_data = that entry's data. Data is never OR-merged across entries.
  - resp_multi = 1 iff two or more entries match.
  - On a miss: resp_idx=0, resp_multi=0, and resp_data = default_out if HAS_DEFAULT else 0.
- Read-vs-write ordering: a lookup accepted in the same cycle as a write or clr sees the table contents from before the edge, i.e. the old values.
- Statistics: on each accept, stat_hits (on a hit) or stat_misses (on a miss) increments by 1.
  - Both counters saturate at 2^CNT_W-1 with no wrap.
  - Neither counter changes on cycles without an accept.
  - Only rst clears them; clr does not.

Test Plan:
- Reset, then lookup key 2'b01 with default_out=2'b11, HAS_DEFAULT=1 -> one cycle later resp_valid=1, resp_hit=0, resp_data=2'b11, stat_misses=1.
- Write idx0 {k=2'b10, d=2'b01} and idx2 {k=2'b10, d=2'b11}, then look up 2'b10 -> resp_hit=1, resp_idx=0, resp_data=2'b01, resp_multi=1, stat_hits=1.
- Hold resp_ready=0 with req_valid=1 across 3 cycles -> req_ready=0 after the first accept, resp_* stable, and only 1 accept counted. Release resp_ready -> the next request is accepted that same cycle.
- Same-cycle write of idx1 {k=2'b11, d=2'b10} and lookup of 2'b11 on an empty table -> that response is a miss. A lookup in the following cycle -> hit with resp_data=2'b10, resp_idx=1.
- clr and wr_en to idx3 in the same cycle, then look up that key -> miss. stat_hits is unchanged by the clr.
- With CNT_W=2, run 5 hitting lookups back-to-back at full rate -> stat_hits saturates at 3. Assert rst mid-stream -> resp_valid=0 and both counters 0 the next cycle.
